serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/response channel bundle for the bit-serial adder sequencer.
// The master drives operands and accepts results; the slave is the adder.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output req_valid, a, b, cin, rsp_ready,
      input  req_ready, rsp_valid, sum, cout, busy
   );

   modport slave (
      input  req_valid, a, b, cin, rsp_ready,
      output req_ready, rsp_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder slice (two half adders plus an OR)
// processes one operand bit per clock, LSB first.
module serial_add_halfadder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_add_ctrl_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             ha0_s, ha0_c, ha1_s, ha1_c;
   logic             bit_sum, bit_carry;
   logic [WIDTH:0]   sum_ext;

   serial_add_halfadder u_ha0 (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .s_o (ha0_s),
      .c_o (ha0_c)
   );

   serial_add_halfadder u_ha1 (
      .a_i (ha0_s),
      .b_i (carry_q),
      .s_o (ha1_s),
      .c_o (ha1_c)
   );

   assign bit_sum   = ha1_s;
   assign bit_carry = ha0_c | ha1_c;
   // New sum bit enters at the MSB; works for WIDTH=1 without a zero-width slice.
   assign sum_ext   = {bit_sum, sum_q} >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = bit_carry;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = sum_ext[WIDTH-1:0];
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances,
// hand-computed expected sums, latency, backpressure and reset behaviour.
module tb_serial_add_ctrl;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   cyc;

   serial_add_ctrl_if #(.WIDTH(8)) if8 ();
   serial_add_ctrl_if #(.WIDTH(1)) if1 ();

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp8(output int n);
      n = 0;
      while (if8.rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
      int n;
      if8.rsp_ready = 1'b1;
      if8.a         = a;
      if8.b         = b;
      if8.cin       = cin;
      if8.req_valid = 1'b1;
      tick();
      if8.req_valid = 1'b0;
      if8.a         = ~a;
      check({tag, "_busy"}, 32'(if8.busy), 32'd1);
      wait_rsp8(n);
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_sum"}, 32'(if8.sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(if8.cout), 32'(exp_cout));
      $display("%s: a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d",
               tag, a, b, cin, if8.sum, if8.cout, n);
      tick();
      check({tag, "_idle_ready"}, 32'(if8.req_ready), 32'd1);
      check({tag, "_idle_rspv"}, 32'(if8.rsp_valid), 32'd0);
   endtask

   initial begin
      int n;
      int t_acc[3];
      logic [7:0] pa[3];
      logic [7:0] pb[3];
      logic       pc[3];
      logic [7:0] ps[3];
      logic       pco[3];
      logic       seen;

      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      if8.req_valid = 1'b0;
      if8.a         = '0;
      if8.b         = '0;
      if8.cin       = 1'b0;
      if8.rsp_ready = 1'b0;
      if1.req_valid = 1'b0;
      if1.a         = '0;
      if1.b         = '0;
      if1.cin       = 1'b0;
      if1.rsp_ready = 1'b0;

      #12;
      check("rst_req_ready", 32'(if8.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(if8.rsp_valid), 32'd0);
      check("rst_busy", 32'(if8.busy), 32'd0);
      check("rst_sum", 32'(if8.sum), 32'd0);
      check("rst_cout", 32'(if8.cout), 32'd0);
      $display("reset: req_ready=%0d rsp_valid=%0d busy=%0d", if8.req_ready, if8.rsp_valid, if8.busy);
      rst_n = 1'b1;
      tick();

      run_op("t1", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
      run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("t2b", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

      // Backpressure: result held for 5 cycles, new requests refused.
      if8.rsp_ready = 1'b0;
      if8.a         = 8'h12;
      if8.b         = 8'h34;
      if8.cin       = 1'b0;
      if8.req_valid = 1'b1;
      tick();
      if8.req_valid = 1'b0;
      wait_rsp8(n);
      check("t3_latency", 32'(n), 32'd8);
      for (int i = 0; i < 5; i++) begin
         if8.req_valid = 1'b1;
         if8.a         = 8'hFF;
         tick();
         check("t3_hold_rspv", 32'(if8.rsp_valid), 32'd1);
         check("t3_hold_ready", 32'(if8.req_ready), 32'd0);
         check("t3_hold_sum", 32'(if8.sum), 32'h46);
         check("t3_hold_cout", 32'(if8.cout), 32'd0);
         $display("t3 hold %0d: rsp_valid=%0d req_ready=%0d sum=%h", i, if8.rsp_valid, if8.req_ready, if8.sum);
      end
      if8.req_valid = 1'b0;
      if8.rsp_ready = 1'b1;
      tick();
      check("t3_xfer_rspv", 32'(if8.rsp_valid), 32'd0);
      check("t3_retain_sum", 32'(if8.sum), 32'h46);
      tick();
      check("t3_single_busy", 32'(if8.busy), 32'd0);
      $display("t3 release: busy=%0d sum=%h", if8.busy, if8.sum);

      // Reset in the middle of RUN.
      if8.a         = 8'hFF;
      if8.b         = 8'hFF;
      if8.cin       = 1'b0;
      if8.req_valid = 1'b1;
      tick();
      if8.req_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("t4_req_ready", 32'(if8.req_ready), 32'd1);
      check("t4_busy", 32'(if8.busy), 32'd0);
      check("t4_rsp_valid", 32'(if8.rsp_valid), 32'd0);
      check("t4_sum", 32'(if8.sum), 32'd0);
      check("t4_cout", 32'(if8.cout), 32'd0);
      #2;
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (if8.rsp_valid === 1'b1) seen = 1'b1;
      end
      check("t4_no_rsp", 32'(seen), 32'd0);
      $display("t4 reset mid-run: busy=%0d rsp_seen=%0d", if8.busy, seen);

      // Back-to-back with req_valid and rsp_ready held high.
      pa[0] = 8'h3C; pb[0] = 8'h0F; pc[0] = 1'b1; ps[0] = 8'h4C; pco[0] = 1'b0;
      pa[1] = 8'h80; pb[1] = 8'h80; pc[1] = 1'b0; ps[1] = 8'h00; pco[1] = 1'b1;
      pa[2] = 8'h7F; pb[2] = 8'h01; pc[2] = 1'b1; ps[2] = 8'h81; pco[2] = 1'b0;
      if8.rsp_ready = 1'b1;
      if8.req_valid = 1'b1;
      if8.a         = pa[0];
      if8.b         = pb[0];
      if8.cin       = pc[0];
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (if8.req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
         tick();
         t_acc[i] = cyc;
         if (i < 2) begin
            if8.a   = pa[i+1];
            if8.b   = pb[i+1];
            if8.cin = pc[i+1];
         end else begin
            if8.req_valid = 1'b0;
            if8.a         = 8'hEE;
         end
         wait_rsp8(n);
         check("t5_latency", 32'(n), 32'd8);
         check("t5_sum", 32'(if8.sum), 32'(ps[i]));
         check("t5_cout", 32'(if8.cout), 32'(pco[i]));
         $display("t5 pair %0d: a=%h b=%h cin=%0d -> sum=%h cout=%0d accept_cyc=%0d",
                  i, pa[i], pb[i], pc[i], if8.sum, if8.cout, t_acc[i]);
      end
      check("t5_spacing01", 32'(t_acc[1] - t_acc[0]), 32'd10);
      check("t5_spacing12", 32'(t_acc[2] - t_acc[1]), 32'd10);
      tick();

      // WIDTH=1 instance.
      if1.rsp_ready = 1'b1;
      if1.a         = 1'b1;
      if1.b         = 1'b1;
      if1.cin       = 1'b1;
      if1.req_valid = 1'b1;
      tick();
      if1.req_valid = 1'b0;
      n = 0;
      while (if1.rsp_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("t6_latency", 32'(n), 32'd1);
      check("t6_sum", 32'(if1.sum), 32'd1);
      check("t6_cout", 32'(if1.cout), 32'd1);
      $display("t6 w1: a=1 b=1 cin=1 -> sum=%0d cout=%0d latency=%0d", if1.sum, if1.cout, n);
      tick();
      check("t6_idle", 32'(if1.req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
